// File: rtl/mcpu_pkg.sv
// mcpu_pkg: state encodings, opcodes, ALUOp and PCSrc codes shared by the multi-cycle CPU
package mcpu_pkg;
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HLT    = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SLL  = 3'b110;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    function automatic logic is_alu(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLT, OP_SLTIU};
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLTZ};
    endfunction

    // Branches compare by subtraction; loads/stores add the offset to the base
    function automatic logic [2:0] alu_code(input logic [5:0] op);
        return (op inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ}) ? ALU_SUB :
               (op == OP_SLT)                      ? ALU_SLT :
               (op == OP_SLTIU)                    ? ALU_SLTU :
               (op inside {OP_AND, OP_ANDI})       ? ALU_AND :
               (op == OP_ORI)                      ? ALU_OR :
               (op == OP_SLL)                      ? ALU_SLL : ALU_ADD;
    endfunction
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: state sequencer and strobe decoder for the multi-cycle CPU
module multicycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             DBDataSrc,
    output logic             RegWre,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);
    state_t st, st_nxt;
    logic   jump_op, taken, dp_on;

    assign jump_op = opcode inside {OP_J, OP_JR, OP_JAL};
    assign taken   = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero) || (opcode == OP_BLTZ && sign);
    assign dp_on   = st inside {S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD};
    assign state   = st;

    // State register and retired-instruction counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            st      <= S_IF;
            retired <= '0;
        end else begin
            st      <= st_nxt;
            retired <= PCWre ? retired + CNT_W'(1) : retired;
        end
    end

    // Next-state sequencing; undefined opcodes fall back to IF as a NOP
    always_comb begin
        case (st)
            S_IF:     st_nxt = S_ID;
            S_ID:     st_nxt = is_alu(opcode)    ? S_EXE_AL :
                               is_branch(opcode) ? S_EXE_BR :
                               (opcode inside {OP_SW, OP_LW}) ? S_EXE_LS :
                               (opcode == OP_HALT) ? S_HLT : S_IF;
            S_EXE_AL: st_nxt = S_WB_AL;
            S_EXE_LS: st_nxt = S_MEM;
            S_MEM:    st_nxt = (opcode == OP_LW) ? S_WB_LD : S_IF;
            S_HLT:    st_nxt = S_HLT;
            default:  st_nxt = S_IF;
        endcase
    end

    // Strobe and mux-select decode; write strobes are suppressed while Reset is high
    always_comb begin
        InsMemRW  = 1'b1;
        ALUSrcA   = dp_on && opcode == OP_SLL;
        ALUSrcB   = dp_on && (opcode inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTIU, OP_SW, OP_LW});
        ALUOp     = dp_on ? alu_code(opcode) : ALU_ADD;
        ExtSel    = dp_on && !(opcode inside {OP_ANDI, OP_ORI, OP_SLTIU});
        RegDst    = (st == S_WB_AL) ? ((opcode inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT}) ? 2'b10 : 2'b01) :
                    (st == S_WB_LD) ? 2'b01 : 2'b00;
        WrRegDSrc = st inside {S_WB_AL, S_WB_LD};
        DBDataSrc = st == S_WB_LD;
        mRD       = st == S_MEM && opcode == OP_LW;
        PCSrc     = (st == S_ID) ? ((opcode == OP_JR) ? PC_RS : (opcode inside {OP_J, OP_JAL}) ? PC_JMP : PC_SEQ) :
                    (st == S_EXE_BR && taken) ? PC_BR : PC_SEQ;
        IRWre     = !Reset && st == S_IF;
        PCWre     = !Reset && ((st == S_ID && jump_op) || st == S_EXE_BR || (st == S_MEM && opcode == OP_SW) ||
                               st == S_WB_AL || st == S_WB_LD);
        RegWre    = !Reset && (st == S_WB_AL || st == S_WB_LD || (st == S_ID && opcode == OP_JAL));
        mWR       = !Reset && st == S_MEM && opcode == OP_SW;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of sequencing, strobes, halt, abort and counter wrap
module tb_multicycle_ctrl;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic [5:0]   opcode = 6'b000000;
    logic         zero = 1'b0;
    logic         sign = 1'b0;
    logic         PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR;
    logic [2:0]   ALUOp;
    logic [1:0]   RegDst, PCSrc;
    logic [3:0]   state;
    logic [W-1:0] retired;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_ret = '0;

    multicycle_ctrl #(.CNT_W(W)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state), .retired(retired)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        opcode = 6'b000000;
        tick();
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (retired !== 4'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
        total++; if (IRWre !== 1'b0) begin bad++; $display("FAIL reset_irwre got=%b want=0", IRWre); end
        total++; if (InsMemRW !== 1'b1) begin bad++; $display("FAIL insmemrw got=%b want=1", InsMemRW); end
        Reset = 1'b0;
        #1;
        total++; if (IRWre !== 1'b1) begin bad++; $display("FAIL if_irwre got=%b want=1", IRWre); end
    endtask

    task automatic test_add();
        logic [3:0] seq [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'b000000;
        zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (state !== seq[i]) begin bad++; $display("FAIL add_state[%0d] got=%0d want=%0d", i, state, seq[i]); end
            total++; if (PCWre !== (seq[i] == 4'd7)) begin bad++; $display("FAIL add_pcwre[%0d] got=%b", i, PCWre); end
            if (seq[i] == 4'd7) begin
                total++; if (RegWre !== 1'b1) begin bad++; $display("FAIL add_regwre got=%b want=1", RegWre); end
                total++; if (RegDst !== 2'b10) begin bad++; $display("FAIL add_regdst got=%b want=10", RegDst); end
                total++; if (ALUOp !== 3'b000) begin bad++; $display("FAIL add_aluop got=%b want=000", ALUOp); end
            end
        end
        exp_ret = 4'd1;
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL add_retired got=%0d want=%0d", retired, exp_ret); end
    endtask

    task automatic test_lw();
        logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b110001;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (state !== seq[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, seq[i]); end
            if (seq[i] == 4'd3) begin
                total++; if (mRD !== 1'b1) begin bad++; $display("FAIL lw_mrd got=%b want=1", mRD); end
                total++; if (mWR !== 1'b0) begin bad++; $display("FAIL lw_mwr got=%b want=0", mWR); end
                total++; if (ALUSrcB !== 1'b1) begin bad++; $display("FAIL lw_alusrcb got=%b want=1", ALUSrcB); end
            end
            if (seq[i] == 4'd4) begin
                total++; if (DBDataSrc !== 1'b1) begin bad++; $display("FAIL lw_dbdatasrc got=%b want=1", DBDataSrc); end
                total++; if (RegWre !== 1'b1) begin bad++; $display("FAIL lw_regwre got=%b want=1", RegWre); end
                total++; if (RegDst !== 2'b01) begin bad++; $display("FAIL lw_regdst got=%b want=01", RegDst); end
            end
        end
        exp_ret = exp_ret + 4'd1;
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL lw_retired got=%0d want=%0d", retired, exp_ret); end
    endtask

    task automatic test_branch();
        logic [5:0] ops [3] = '{6'b110100, 6'b110101, 6'b110110};
        logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
        logic       ss  [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0] pcs [3] = '{2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 3; i++) begin
            opcode = ops[i];
            zero = zs[i];
            sign = ss[i];
            tick();
            tick();
            total++; if (state !== 4'd5) begin bad++; $display("FAIL br_state[%0d] got=%0d want=5", i, state); end
            total++; if (PCSrc !== pcs[i]) begin bad++; $display("FAIL br_pcsrc[%0d] got=%b want=%b", i, PCSrc, pcs[i]); end
            total++; if (PCWre !== 1'b1) begin bad++; $display("FAIL br_pcwre[%0d] got=%b want=1", i, PCWre); end
            total++; if (ALUOp !== 3'b001) begin bad++; $display("FAIL br_aluop[%0d] got=%b want=001", i, ALUOp); end
            tick();
            exp_ret = exp_ret + 4'd1;
            total++; if (state !== 4'd0) begin bad++; $display("FAIL br_next[%0d] got=%0d want=0", i, state); end
        end
        zero = 1'b0;
        sign = 1'b0;
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL br_retired got=%0d want=%0d", retired, exp_ret); end
    endtask

    task automatic test_jal();
        opcode = 6'b111010;
        tick();
        total++; if (state !== 4'd1) begin bad++; $display("FAIL jal_state got=%0d want=1", state); end
        total++; if (PCSrc !== 2'b11) begin bad++; $display("FAIL jal_pcsrc got=%b want=11", PCSrc); end
        total++; if (RegWre !== 1'b1) begin bad++; $display("FAIL jal_regwre got=%b want=1", RegWre); end
        total++; if (RegDst !== 2'b00) begin bad++; $display("FAIL jal_regdst got=%b want=00", RegDst); end
        total++; if (WrRegDSrc !== 1'b0) begin bad++; $display("FAIL jal_wrregdsrc got=%b want=0", WrRegDSrc); end
        total++; if (PCWre !== 1'b1) begin bad++; $display("FAIL jal_pcwre got=%b want=1", PCWre); end
        tick();
        exp_ret = exp_ret + 4'd1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL jal_next got=%0d want=0", state); end
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL jal_retired got=%0d want=%0d", retired, exp_ret); end
    endtask

    task automatic test_halt();
        opcode = 6'b111111;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            total++; if (state !== 4'd8) begin bad++; $display("FAIL hlt_state[%0d] got=%0d want=8", i, state); end
            total++; if ({PCWre, IRWre, RegWre, mWR, mRD} !== 5'b0) begin bad++; $display("FAIL hlt_strobes[%0d] got=%b want=00000", i, {PCWre, IRWre, RegWre, mWR, mRD}); end
            tick();
        end
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL hlt_retired got=%0d want=%0d", retired, exp_ret); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_ret = '0;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL hlt_reset_state got=%0d want=0", state); end
        total++; if (retired !== 4'd0) begin bad++; $display("FAIL hlt_reset_retired got=%0d want=0", retired); end
    endtask

    task automatic test_undef();
        opcode = 6'b001111;
        tick();
        total++; if (PCWre !== 1'b0) begin bad++; $display("FAIL undef_pcwre got=%b want=0", PCWre); end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL undef_next got=%0d want=0", state); end
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL undef_retired got=%0d want=%0d", retired, exp_ret); end
    endtask

    task automatic test_sw_abort();
        opcode = 6'b110000;
        tick();
        tick();
        tick();
        total++; if (mWR !== 1'b1) begin bad++; $display("FAIL sw_mwr got=%b want=1", mWR); end
        total++; if (PCWre !== 1'b1) begin bad++; $display("FAIL sw_pcwre got=%b want=1", PCWre); end
        tick();
        exp_ret = exp_ret + 4'd1;
        total++; if (retired !== exp_ret) begin bad++; $display("FAIL sw_retired got=%0d want=%0d", retired, exp_ret); end
        tick();
        tick();
        tick();
        Reset = 1'b1;
        #1;
        total++; if (state !== 4'd3) begin bad++; $display("FAIL abort_state got=%0d want=3", state); end
        total++; if ({mWR, PCWre, RegWre} !== 3'b000) begin bad++; $display("FAIL abort_strobes got=%b want=000", {mWR, PCWre, RegWre}); end
        tick();
        Reset = 1'b0;
        exp_ret = '0;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL abort_next got=%0d want=0", state); end
        total++; if (retired !== 4'd0) begin bad++; $display("FAIL abort_retired got=%0d want=0", retired); end
    endtask

    task automatic test_wrap();
        opcode = 6'b111000;
        for (int i = 0; i < 16; i++) begin
            tick();
            tick();
            exp_ret = exp_ret + 4'd1;
        end
        total++; if (retired !== 4'd0) begin bad++; $display("FAIL wrap_retired got=%0d want=0", retired); end
        total++; if (exp_ret !== 4'd0) begin bad++; $display("FAIL wrap_model got=%0d want=0", exp_ret); end
    endtask

    task automatic test_preload_wrap();
        opcode = 6'b111000;
        for (int i = 0; i < 15; i++) begin
            tick();
            tick();
        end
        total++; if (retired !== 4'hF) begin bad++; $display("FAIL preload_retired got=%0d want=15", retired); end
        opcode = 6'b000001;
        for (int i = 0; i < 4; i++) tick();
        total++; if (retired !== 4'd0) begin bad++; $display("FAIL wrap_after_sub got=%0d want=0", retired); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_branch();
        test_jal();
        test_halt();
        test_undef();
        test_sw_abort();
        test_wrap();
        test_preload_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
